// File: rtl/seg7_serial_out_if.sv
// seg7_serial_out_if
// Groups the frame handshake and the serial display bus of seg7_serial_out.
//   start     upstream -> block : request one frame transfer
//   pattern   upstream -> block : 64-bit segment pattern, [63] shifted first
//   busy      block -> upstream : transfer in progress
//   done      block -> upstream : one-cycle pulse, frame shifted and latched
//   seg_clk   block -> board    : serial shift clock (board samples on rising edge)
//   seg_sout  block -> board    : serial data
//   seg_latch block -> board    : storage-register clock pulse
//   seg_clrn  block -> board    : active-low clear of the shift registers
// The master modport is the upstream side; the slave modport is seg7_serial_out.
interface seg7_serial_out_if;
  logic        start;
  logic [63:0] pattern;
  logic        busy;
  logic        done;
  logic        seg_clk;
  logic        seg_sout;
  logic        seg_latch;
  logic        seg_clrn;

  modport master (
    output start, pattern,
    input  busy, done, seg_clk, seg_sout, seg_latch, seg_clrn
  );

  modport slave (
    input  start, pattern,
    output busy, done, seg_clk, seg_sout, seg_latch, seg_clrn
  );
endinterface

// File: rtl/seg7_serial_out.sv
// seg7_serial_out
// Shifts a 64-bit segment pattern MSB-first into the board's chained 8-bit
// SIPO registers using a divided serial clock, then pulses the storage latch
// so all eight digits update together.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous, active-high reset
//   bus  seg7_serial_out_if.slave (start/pattern in; busy/done/seg_* out)
// Parameter:
//   HALF  clk cycles per serial-clock half period (1..255)
// Build option:
//   SEG7_AUTO_REFRESH_EN  when defined, start is ignored and frames run
//                         continuously from reset release, recapturing
//                         pattern in every DONE cycle.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for start; all serial outputs low
// S_SHIFT_LO | seg_clk low for HALF cycles, seg_sout presents current MSB
// S_SHIFT_HI | seg_clk high for HALF cycles; shift and count at phase end
// S_LATCH    | seg_latch high for HALF cycles after bit 63
// S_DONE     | one-cycle done pulse; may accept the next start directly
module seg7_serial_out #(
  parameter int unsigned HALF = 2
) (
  input  logic              clk,
  input  logic              rst,
  seg7_serial_out_if.slave  bus
);

  localparam int unsigned PW = $clog2(HALF + 1);
  localparam logic [PW-1:0] PH_LOAD = PW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   sr_q, sr_d;
  logic [5:0]    bit_q, bit_d;
  logic [PW-1:0] ph_q, ph_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          sclk_q, sclk_d;
  logic          sout_q, sout_d;
  logic          latch_q, latch_d;
  logic          clrn_q, clrn_d;

  logic          start_eff;
  logic          phase_end;

`ifdef SEG7_AUTO_REFRESH_EN
  logic unused_start;
  assign unused_start = bus.start;
  assign start_eff    = 1'b1;
`else
  assign start_eff    = bus.start;
`endif

  // Phase timer is a down-counter loaded with HALF-1; terminal count is zero.
  assign phase_end = (ph_q == '0);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sclk_d  = sclk_q;
    sout_d  = sout_q;
    latch_d = latch_q;
    clrn_d  = 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        sclk_d  = 1'b0;
        sout_d  = 1'b0;
        latch_d = 1'b0;
        if (start_eff) begin
          state_d = S_SHIFT_LO;
          sr_d    = bus.pattern;
          bit_d   = 6'd0;
          ph_d    = PH_LOAD;
          busy_d  = 1'b1;
          sout_d  = bus.pattern[63];
        end
      end

      S_SHIFT_LO: begin
        if (phase_end) begin
          state_d = S_SHIFT_HI;
          ph_d    = PH_LOAD;
          sclk_d  = 1'b1;
        end else begin
          ph_d = ph_q - PW'(1);
        end
      end

      S_SHIFT_HI: begin
        if (phase_end) begin
          sr_d   = {sr_q[62:0], 1'b0};
          bit_d  = bit_q + 6'd1;
          ph_d   = PH_LOAD;
          sclk_d = 1'b0;
          if (bit_q == 6'd63) begin
            state_d = S_LATCH;
            latch_d = 1'b1;
            sout_d  = 1'b0;
          end else begin
            // Output register is loaded with the bit that becomes MSB after
            // this shift, so seg_sout is already valid in the first LO cycle.
            state_d = S_SHIFT_LO;
            sout_d  = sr_q[62];
          end
        end else begin
          ph_d = ph_q - PW'(1);
        end
      end

      S_LATCH: begin
        if (phase_end) begin
          state_d = S_DONE;
          latch_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          ph_d = ph_q - PW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      ph_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sout_q  <= 1'b0;
      latch_q <= 1'b0;
      clrn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      sout_q  <= sout_d;
      latch_q <= latch_d;
      clrn_q  <= clrn_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.seg_clk   = sclk_q;
  assign bus.seg_sout  = sout_q;
  assign bus.seg_latch = latch_q;
  assign bus.seg_clrn  = clrn_q;

endmodule

// File: tb/tb_seg7_serial_out.sv
// tb_seg7_serial_out
// Two instances share clk/rst: dut2 (HALF=2) and dut1 (HALF=1).
// The reference model tracks, per instance, the offset k of the current cycle
// inside a frame (0 = idle) and derives every output from k, HALF and the
// captured pattern. Directed sequences add literal expectations on frame
// timing and on the bits collected at seg_clk rising edges.
module tb_seg7_serial_out;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_serial_out_if b2 ();
  seg7_serial_out_if b1 ();

  seg7_serial_out #(.HALF(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  seg7_serial_out #(.HALF(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  int          mk2 = 0, mk1 = 0;
  logic [63:0] mpat2 = '0, mpat1 = '0;
  logic        mclrn = 1'b0;

  function automatic logic accept(input int k, input int h, input logic st);
    logic s;
`ifdef SEG7_AUTO_REFRESH_EN
    s = 1'b1;
`else
    s = st;
`endif
    return ((k == 0) || (k == 129*h + 1)) && s;
  endfunction

  function automatic int advance(input int k, input int h);
    if (k == 0 || k == 129*h + 1) return 0;
    return k + 1;
  endfunction

  // {busy, done, seg_clk, seg_sout, seg_latch} for frame offset k
  function automatic logic [4:0] exp_out(input int k, input int h, input logic [63:0] p);
    int b;
    logic hi;
    if (k == 0) return 5'b00000;
    if (k <= 128*h) begin
      b  = (k - 1) / (2*h);
      hi = (((k - 1) % (2*h)) >= h);
      return {1'b1, 1'b0, hi, p[63-b], 1'b0};
    end
    if (k <= 129*h) return 5'b10001;
    return 5'b01000;
  endfunction

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    mclrn <= !rst;
    if (rst) begin
      mk2 <= 0;
      mk1 <= 0;
    end else begin
      if (accept(mk2, 2, b2.start)) begin
        mk2   <= 1;
        mpat2 <= b2.pattern;
      end else mk2 <= advance(mk2, 2);
      if (accept(mk1, 1, b1.start)) begin
        mk1   <= 1;
        mpat1 <= b1.pattern;
      end else mk1 <= advance(mk1, 1);
    end
  end

  // ---------------- compare + monitors ----------------
  logic [63:0] cap2 = '0;
  int ncap2 = 0, nlatch2 = 0, ndone2 = 0, nbusy2 = 0;
  int first_busy2 = -1, last_busy2 = -1, done_cyc2 = -1, last_done2 = -1, bad_iv2 = 0;
  int ndone1 = 0, last_done1 = -1, bad_iv1 = 0, nlow1 = 0;
  logic win1 = 1'b0;
  logic prev_clk2 = 1'b0;

  always @(negedge clk) begin
    chk("out_dut2", {b2.busy, b2.done, b2.seg_clk, b2.seg_sout, b2.seg_latch, b2.seg_clrn},
        {exp_out(mk2, 2, mpat2), mclrn});
    chk("out_dut1", {b1.busy, b1.done, b1.seg_clk, b1.seg_sout, b1.seg_latch, b1.seg_clrn},
        {exp_out(mk1, 1, mpat1), mclrn});

    if (b2.seg_clk === 1'b1 && prev_clk2 === 1'b0) begin
      cap2 = {cap2[62:0], b2.seg_sout};
      ncap2++;
    end
    prev_clk2 = b2.seg_clk;
    if (b2.seg_latch === 1'b1) nlatch2++;
    if (b2.busy === 1'b1) begin
      nbusy2++;
      if (first_busy2 < 0) first_busy2 = cyc;
      last_busy2 = cyc;
    end
    if (b2.done === 1'b1) begin
      if (last_done2 >= 0 && (cyc - last_done2) != 259) bad_iv2++;
      last_done2 = cyc;
      done_cyc2  = cyc;
      ndone2++;
    end

    if (b1.done === 1'b1) begin
      if (last_done1 >= 0 && (cyc - last_done1) != 130) bad_iv1++;
      last_done1 = cyc;
      ndone1++;
    end
    if (win1 && b1.busy !== 1'b1) nlow1++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon2();
    cap2 = '0; ncap2 = 0; nlatch2 = 0; ndone2 = 0; nbusy2 = 0;
    first_busy2 = -1; last_busy2 = -1; done_cyc2 = -1; last_done2 = -1; bad_iv2 = 0;
  endtask

  task automatic wait_done2(input int maxc);
    for (int i = 0; i < maxc && ndone2 == 0; i++) tick();
  endtask

  localparam logic [63:0] P1 = 64'hA5C3_0F0F_1234_FEDC;
  localparam logic [63:0] P2 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] P3 = 64'hFFFF_0000_AAAA_5555;
  localparam logic [63:0] P4 = 64'h8000_0000_0000_0001;
  localparam logic [63:0] P5 = 64'hDEAD_BEEF_CAFE_F00D;

  int n0;

  initial begin
    b2.start = 1'b0; b2.pattern = '0;
    b1.start = 1'b0; b1.pattern = '0;

    // ---- reset: held for 3 cycles ----
    tick(); tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_clrn_low", {63'd0, b2.seg_clrn}, 64'd0);
    chk("rst_outs_zero", {59'd0, b2.busy, b2.done, b2.seg_clk, b2.seg_sout, b2.seg_latch}, 64'd0);
    @(negedge clk);
    chk("clrn_after_release", {63'd0, b2.seg_clrn}, 64'd1);
    chk("busy_after_release", {63'd0, b2.busy}, 64'd0);

`ifdef SEG7_AUTO_REFRESH_EN
    // ---- auto refresh: start tied low, pattern changed between frames ----
    clr_mon2();
    b2.pattern = P1;
    for (int i = 0; i < 800; i++) begin
      if (i == 200) b2.pattern = P2;
      if (i == 450) b2.pattern = P3;
      tick();
    end
    chk("auto_done_count", ndone2, 3);
    chk("auto_done_period", bad_iv2, 0);
    chk("auto_last_frame_bits", cap2, P3);
`else
    tick();
    // ---- single frame, HALF=2 ----
    clr_mon2();
    b2.pattern = P1;
    b2.start   = 1'b1;
    n0 = cyc;
    tick();
    b2.start = 1'b0;
    wait_done2(400);
    tick(); tick();
    chk("frame_first_busy", first_busy2, n0 + 1);
    chk("frame_last_busy", last_busy2, n0 + 258);
    chk("frame_busy_len", nbusy2, 258);
    chk("frame_clk_edges", ncap2, 64);
    chk("frame_bits", cap2, P1);
    chk("frame_latch_width", nlatch2, 2);
    chk("frame_done_cycle", done_cyc2, n0 + 259);
    chk("frame_done_count", ndone2, 1);

    // ---- busy ignore + data hold ----
    clr_mon2();
    b2.pattern = P2;
    b2.start   = 1'b1;
    tick();
    b2.start = 1'b0;
    repeat (50) tick();
    b2.pattern = 64'h0;
    b2.start   = 1'b1;
    tick();
    b2.start = 1'b0;
    repeat (300) tick();
    chk("ignore_bits", cap2, P2);
    chk("ignore_done_count", ndone2, 1);
    chk("ignore_clk_edges", ncap2, 64);

    // ---- back-to-back, HALF=1, start held high ----
    ndone1 = 0; last_done1 = -1; bad_iv1 = 0; nlow1 = 0;
    b1.pattern = P5;
    b1.start   = 1'b1;
    tick();
    win1 = 1'b1;
    for (int i = 0; i < 520; i++) begin
      if (i == 300) b1.pattern = P3;
      tick();
    end
    win1 = 1'b0;
    b1.start = 1'b0;
    chk("b2b_done_count", ndone1, 4);
    chk("b2b_done_period", bad_iv1, 0);
    chk("b2b_busy_low", nlow1, 4);
    repeat (200) tick();

    // ---- mid-frame reset at bit 20, HALF=2 ----
    clr_mon2();
    b2.pattern = P3;
    b2.start   = 1'b1;
    tick();
    b2.start = 1'b0;
    repeat (80) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("abort_seg_clk", {63'd0, b2.seg_clk}, 64'd0);
    chk("abort_clrn", {63'd0, b2.seg_clrn}, 64'd0);
    chk("abort_busy", {63'd0, b2.busy}, 64'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("abort_no_latch", nlatch2, 0);
    chk("abort_no_done", ndone2, 0);
    chk("abort_bits_seen", ncap2, 20);

    clr_mon2();
    b2.pattern = P4;
    b2.start   = 1'b1;
    tick();
    b2.start = 1'b0;
    wait_done2(400);
    tick();
    chk("restart_clk_edges", ncap2, 64);
    chk("restart_bits", cap2, P4);
    chk("restart_latch_width", nlatch2, 2);
    chk("restart_done_count", ndone2, 1);
`endif

    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
